// File: rtl/syndrome_scale_multi_pkg.sv
// Shared encodings and sizing helpers for the syndrome scaling datapath.
// Widths come from CLOG2 so single-entry ranges still get a 1-bit field.
`ifndef SYNDROME_SCALE_MULTI_CLOG2
`define SYNDROME_SCALE_MULTI_CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package syndrome_scale_multi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLD   = 3'd1,
    SLD   = 3'd2,
    MUL   = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic int depth_of(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Number of live lanes in the final S word.
  function automatic int last_lanes(input int n, input int d);
    return n - (depth_of(n, d) - 1) * d;
  endfunction

endpackage

// File: rtl/syndrome_scale_multi_gf2m_mul.sv
// GF(2^M) multiplier, reduction polynomial x^M + POLY (default x^79 + x^9 + 1).
// Latency: done pulses exactly DELAY cycles after start; op_c is held until the next start.
// Backpressure: none; a new start restarts the operation.
module gf2m_mul #(
  parameter int             M     = 79,
  parameter int             DELAY = 6,
  parameter logic [M-1:0]   POLY  = M'('h201)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [M-1:0] op_a,
  input  logic [M-1:0] op_b,
  output logic         done,
  output logic [M-1:0] op_c
);
  localparam int CW = `CLOG2(DELAY + 1);

  logic [CW-1:0] cnt;

  // MSB-first Horner form: reduce the accumulator before each new partial product.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0);
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt  <= '0;
      op_c <= '0;
    end else if (start) begin
      cnt  <= CW'(DELAY);
      op_c <= gf_mul(op_a, op_b);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/syndrome_scale_multi.sv
// Computes S_k = f_k * S for k < num_f, writing one GF(2^m) element per WRITE cycle.
// Latency: (DELAY_rd+1) per factor and per S word, DELAY_mul+2 per element (2 if f_k == 0).
// Backpressure: none; start is ignored while busy, results are written unconditionally.
module syndrome_scale_multi
  import syndrome_scale_multi_pkg::*;
#(
  parameter int n         = 47,
  parameter int m         = 79,
  parameter int d         = 5,
  parameter int K         = 2,
  parameter int DELAY_mul = 6,
  parameter int DELAY_rd  = 1,
  parameter int WIDTH     = m * d,
  parameter int DEPTH     = depth_of(n, d)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     start,
  input  logic [`CLOG2(K+1)-1:0]   num_f,
  output logic                     busy,
  output logic                     finish,
  input  logic [WIDTH-1:0]         S_din,
  output logic [`CLOG2(DEPTH)-1:0] S_addr,
  output logic                     S_rw,
  input  logic [m-1:0]             f_din,
  output logic [`CLOG2(K)-1:0]     f_addr,
  output logic                     f_rw,
  output logic [m-1:0]             S_out_dout,
  output logic [`CLOG2(K*n)-1:0]   S_out_addr,
  output logic                     S_out_rw
);
  localparam int KW = `CLOG2(K + 1);
  localparam int FW = `CLOG2(K);
  localparam int AW = `CLOG2(DEPTH);
  localparam int OW = `CLOG2(K * n);
  localparam int JW = `CLOG2(n);
  localparam int LW = `CLOG2(d);
  localparam int RW = `CLOG2(DELAY_rd + 1);

  state_t           state, state_nx;
  logic [KW-1:0]    nf, k;
  logic [JW-1:0]    j;
  logic [AW-1:0]    w;
  logic [LW-1:0]    lane;
  logic [RW-1:0]    rd_cnt;
  logic [m-1:0]     f_reg, result, mul_c;
  logic [WIDTH-1:0] sreg;
  logic             mul_start, mul_done;
  logic             rd_last, last_elem, last_factor;

  assign rd_last     = (rd_cnt == RW'(DELAY_rd));
  assign last_elem   = (j == JW'(n - 1));
  assign last_factor = (k == nf - 1'b1);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = ((num_f != '0) && (num_f <= KW'(K))) ? FLD : DONE;
      FLD:   if (rd_last) state_nx = SLD;
      SLD:   if (rd_last) state_nx = MUL;
      MUL: begin
        if (f_reg != '0) begin
          mul_start = 1'b1;
          state_nx  = WAIT;
        end else begin
          state_nx  = WRITE;
        end
      end
      WAIT:  if (mul_done) state_nx = WRITE;
      WRITE: begin
        if (last_elem && last_factor)  state_nx = DONE;
        else if (last_elem)            state_nx = FLD;
        else if (lane == LW'(d - 1))   state_nx = SLD;
        else                           state_nx = MUL;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      nf     <= '0;
      k      <= '0;
      j      <= '0;
      w      <= '0;
      lane   <= '0;
      rd_cnt <= '0;
      f_reg  <= '0;
      sreg   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nf     <= num_f;
          k      <= '0;
          j      <= '0;
          w      <= '0;
          lane   <= '0;
          rd_cnt <= '0;
        end
        FLD: begin
          rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
          if (rd_last) f_reg <= f_din;
        end
        SLD: begin
          rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
          if (rd_last) sreg <= S_din;
        end
        MUL:  if (f_reg == '0) result <= '0;
        WAIT: if (mul_done) result <= mul_c;
        WRITE: begin
          if (last_elem) begin
            // Park k at 0 after the final factor so f_addr never points past num_f-1.
            k    <= last_factor ? '0 : k + 1'b1;
            j    <= '0;
            w    <= '0;
            lane <= '0;
          end else if (lane == LW'(d - 1)) begin
            w    <= w + 1'b1;
            lane <= '0;
            j    <= j + 1'b1;
          end else begin
            sreg <= {sreg[WIDTH-m-1:0], {m{1'b0}}};
            lane <= lane + 1'b1;
            j    <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  gf2m_mul #(
    .M     (m),
    .DELAY (DELAY_mul)
  ) u_mul (
    .clk   (clk),
    .rst_b (rst_b),
    .start (mul_start),
    .op_a  (sreg[WIDTH-1 -: m]),
    .op_b  (f_reg),
    .done  (mul_done),
    .op_c  (mul_c)
  );

  assign busy       = (state != IDLE);
  assign finish     = (state == DONE);
  assign S_addr     = w;
  assign S_rw       = 1'b0;
  assign f_addr     = k[FW-1:0];
  assign f_rw       = 1'b0;
  assign S_out_rw   = (state == WRITE);
  assign S_out_dout = result;
  assign S_out_addr = OW'(int'(k) * n + int'(j));

endmodule

// File: tb/tb_syndrome_scale_multi.sv
// Directed bench for syndrome_scale_multi: default n=47 instance plus an n=10 instance.
module tb_syndrome_scale_multi;
  import syndrome_scale_multi_pkg::*;

  localparam int M   = 79;
  localparam int N0  = 47;
  localparam int N1  = 10;
  localparam int DL  = 5;
  localparam int WID = M * DL;

  logic       clk   = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       sel   = 1'b0;
  logic [1:0] num_f = '0;

  always #5 clk = ~clk;

  logic start0, start1;
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  logic busy0, fin0, srw0, frw0, orw0;
  logic [WID-1:0] sdin0;
  logic [3:0]     saddr0;
  logic [M-1:0]   fdin0, dout0;
  logic [0:0]     faddr0;
  logic [6:0]     oaddr0;

  logic busy1, fin1, srw1, frw1, orw1;
  logic [WID-1:0] sdin1;
  logic [0:0]     saddr1;
  logic [M-1:0]   fdin1, dout1;
  logic [0:0]     faddr1;
  logic [4:0]     oaddr1;

  syndrome_scale_multi dut0 (
    .clk(clk), .rst_b(rst_b), .start(start0), .num_f(num_f), .busy(busy0), .finish(fin0),
    .S_din(sdin0), .S_addr(saddr0), .S_rw(srw0), .f_din(fdin0), .f_addr(faddr0), .f_rw(frw0),
    .S_out_dout(dout0), .S_out_addr(oaddr0), .S_out_rw(orw0)
  );

  syndrome_scale_multi #(.n(N1)) dut1 (
    .clk(clk), .rst_b(rst_b), .start(start1), .num_f(num_f), .busy(busy1), .finish(fin1),
    .S_din(sdin1), .S_addr(saddr1), .S_rw(srw1), .f_din(fdin1), .f_addr(faddr1), .f_rw(frw1),
    .S_out_dout(dout1), .S_out_addr(oaddr1), .S_out_rw(orw1)
  );

  logic         m_rw, m_fin, m_busy, m_faddr, m_mulst;
  logic [6:0]   m_addr;
  logic [M-1:0] m_dout;
  logic [3:0]   m_saddr;
  assign m_rw    = sel ? orw1 : orw0;
  assign m_fin   = sel ? fin1 : fin0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_faddr = sel ? faddr1[0] : faddr0[0];
  assign m_mulst = sel ? dut1.mul_start : dut0.mul_start;
  assign m_addr  = sel ? {2'b00, oaddr1} : oaddr0;
  assign m_dout  = sel ? dout1 : dout0;
  assign m_saddr = sel ? {3'b000, saddr1} : saddr0;

  logic [M-1:0]   s_elem [N0];
  logic [M-1:0]   f_mem  [2];
  logic [WID-1:0] smem   [10];

  // Memories with one cycle of read latency.
  int sa0_q = 0, sa1_q = 0, fa0_q = 0, fa1_q = 0;
  always @(negedge clk) begin
    sdin0 = smem[sa0_q];
    sa0_q = (int'(saddr0) < 10) ? int'(saddr0) : 0;
    sdin1 = smem[sa1_q];
    sa1_q = int'(saddr1);
    fdin0 = f_mem[fa0_q];
    fa0_q = int'(faddr0);
    fdin1 = f_mem[fa1_q];
    fa1_q = int'(faddr1);
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] rand79();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[M-1:0];
  endfunction

  // Full carry-less product, then fold bits >= 79 down using x^79 = x^9 + 1.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
    for (int i = 2 * M - 2; i >= M; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p = p ^ ({{(2*M-10){1'b0}}, 10'h201} << (i - M));
      end
    return p[M-1:0];
  endfunction

  task automatic pack_s();
    for (int w = 0; w < 10; w++)
      for (int l = 0; l < DL; l++)
        smem[w][WID-1-l*M -: M] = (w * DL + l < N0) ? s_elem[w*DL+l] : rand79();
  endtask

  int           wa[$];
  logic [M-1:0] wd[$];
  int           wt[$];
  int fin_cnt, fin_cyc, busy_lo, busy_after, f1_seen, mulk1, saddr_max, aborted, extra, nwr;

  task automatic do_pass(input string tag, input bit use10, input logic [1:0] nf,
                         input int abort_j, input int poke_at, input int budget);
    int cyc;
    bit done;
    wa.delete(); wd.delete(); wt.delete();
    fin_cnt = 0; fin_cyc = -1; busy_lo = 0; busy_after = 0; f1_seen = 0;
    mulk1 = 0; saddr_max = 0; aborted = 0; extra = 0; nwr = 0;
    sel = use10;
    num_f = nf;
    start = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke_at > 1 && cyc == poke_at) begin
        start = 1'b1;
        num_f = 2'd1;
      end else if (poke_at > 1 && cyc == poke_at + 1) begin
        start = 1'b0;
      end
      if (m_rw) begin
        wa.push_back(int'(m_addr));
        wd.push_back(m_dout);
        wt.push_back(cyc);
      end
      if (m_fin) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = cyc;
      end
      if (!m_busy && (fin_cyc < 0 || cyc <= fin_cyc)) busy_lo++;
      if (m_busy && fin_cyc >= 0 && cyc > fin_cyc) busy_after++;
      if (m_faddr) f1_seen = 1;
      if (m_faddr && m_mulst) mulk1++;
      if (int'(m_saddr) > saddr_max) saddr_max = int'(m_saddr);
      if (abort_j >= 0 && !use10 && dut0.state == WAIT && int'(dut0.j) == abort_j) begin
        nwr = wa.size();
        #2 rst_b = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, m_busy, 0);
        chk({tag, "_rst_wr"}, m_rw, 0);
        chk({tag, "_rst_oaddr"}, m_addr, 0);
        chk({tag, "_rst_dout"}, m_dout, 0);
        chk({tag, "_rst_saddr"}, m_saddr, 0);
        repeat (3) begin
          @(negedge clk);
          if (m_rw) extra++;
          if (m_fin) fin_cnt++;
        end
        rst_b = 1'b1;
        aborted = 1;
      end
      done = (aborted != 0) || (fin_cyc >= 0 && cyc >= fin_cyc + 3) || (cyc >= budget);
    end
    if (abort_j < 0) chk({tag, "_done_in_budget"}, (fin_cyc >= 0), 1);
  endtask

  task automatic verify(input string tag, input int nn, input int nf);
    int bad_a, bad_d, lim;
    bad_a = 0;
    bad_d = 0;
    lim = (wa.size() < nf * nn) ? wa.size() : nf * nn;
    chk({tag, "_wr_count"}, wa.size(), nf * nn);
    for (int i = 0; i < lim; i++) begin
      if (wa[i] != i) bad_a++;
      if (wd[i] !== ref_mul(s_elem[i % nn], f_mem[i / nn])) bad_d++;
    end
    chk({tag, "_addr_seq"}, bad_a, 0);
    chk({tag, "_data"}, bad_d, 0);
    chk({tag, "_finish_cnt"}, fin_cnt, 1);
    chk({tag, "_busy_hold"}, busy_lo, 0);
    chk({tag, "_busy_drop"}, busy_after, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    for (int i = 0; i < N0; i++) s_elem[i] = rand79();
    f_mem[0] = rand79() | M'(1);
    f_mem[1] = rand79() | M'(1);
    pack_s();

    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_finish", fin0, 0);
    chk("rst_wr", orw0, 0);
    chk("rst_oaddr", oaddr0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_saddr", saddr0, 0);
    chk("rst_faddr", faddr0, 0);
    chk("rst_srw", srw0, 0);
    chk("rst_frw", frw0, 0);
    chk("rst_busy1", busy1, 0);
    rst_b = 1'b1;
    @(negedge clk);

    do_pass("t1", 1'b0, 2'd2, -1, 0, 3000);
    verify("t1", N0, 2);

    do_pass("t2", 1'b0, 2'd1, -1, 0, 3000);
    verify("t2", N0, 1);
    chk("t2_faddr1_seen", f1_seen, 0);

    // Invalid counts: the start cycle plus the DONE cycle, nothing written.
    do_pass("t3a", 1'b0, 2'd0, -1, 0, 50);
    chk("t3a_len", fin_cyc + 1, 2);
    chk("t3a_wr", wa.size(), 0);
    chk("t3a_finish_cnt", fin_cnt, 1);
    do_pass("t3b", 1'b0, 2'd3, -1, 0, 50);
    chk("t3b_len", fin_cyc + 1, 2);
    chk("t3b_wr", wa.size(), 0);

    // x^78 * x = x^79 = x^9 + 1; (x^78 + 1) * x = x^9 + x + 1.
    s_elem[0] = {1'b1, 78'd0};
    s_elem[1] = {1'b1, 78'd1};
    f_mem[0]  = M'(2);
    f_mem[1]  = '0;
    pack_s();
    do_pass("t4", 1'b0, 2'd2, -1, 0, 3000);
    verify("t4", N0, 2);
    chk("t4_mul_k1", mulk1, 0);
    chk("t4_e0", (wd.size() > 0) ? wd[0] : '1, M'('h201));
    chk("t4_e1", (wd.size() > 1) ? wd[1] : '1, M'('h203));
    nz = 0;
    for (int i = N0; i < wd.size(); i++) if (wd[i] != '0) nz++;
    chk("t4_k1_zero", nz, 0);

    f_mem[0] = rand79() | M'(1);
    f_mem[1] = rand79() | M'(1);
    // Each factor: one f load, two S word loads, ten multiplies = 3*2 + 10*8.
    do_pass("t5", 1'b1, 2'd2, -1, 0, 600);
    verify("t5", N1, 2);
    chk("t5_saddr_max", saddr_max, 1);
    chk("t5_factor_cycles", (wt.size() > 10) ? wt[10] - wt[0] : -1, 86);

    do_pass("t6a", 1'b0, 2'd2, 20, 0, 3000);
    chk("t6a_abort_hit", aborted, 1);
    chk("t6a_pre_abort_wr", nwr, 20);
    chk("t6a_post_rst_wr", extra, 0);
    chk("t6a_no_finish", fin_cnt, 0);

    do_pass("t6b", 1'b0, 2'd2, -1, 100, 3000);
    verify("t6b", N0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
